// File: rtl/fxp_pkg.sv
// Shared types and width/bound helpers for the fixed-point MAC pipeline.
package fxp_pkg;

    typedef struct packed {
        logic clr;
        logic last;
        logic rnd;
        logic sat;
    } beat_ctl_t;

    function automatic int calc_total_bits(int int_bits, int frac_bits);
        return int_bits + frac_bits;
    endfunction

    function automatic int calc_acc_w(int total_bits, int guard_bits);
        return 2 * total_bits + guard_bits;
    endfunction

    // Two's-complement bounds as 64-bit patterns; callers size-cast to their width.
    function automatic logic [63:0] sat_max(int total_bits);
        return (64'd1 << (total_bits - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(int total_bits);
        return 64'd1 << (total_bits - 1);
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Accumulator to QINT.FRAC conversion: optional half-up rounding, shift, range
// check, then saturate or wrap.
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int ACC_W      = 40,
    parameter int FRAC_BITS  = 8,
    parameter int TOTAL_BITS = 16
) (
    input  logic signed [ACC_W-1:0]      acc_i,
    input  logic                         round_en_i,
    input  logic                         sat_en_i,
    output logic        [TOTAL_BITS-1:0] result_o,
    output logic                         overflow_o
);

    localparam logic [TOTAL_BITS-1:0] SAT_MAX = TOTAL_BITS'(sat_max(TOTAL_BITS));
    localparam logic [TOTAL_BITS-1:0] SAT_MIN = TOTAL_BITS'(sat_min(TOTAL_BITS));
    localparam logic signed [ACC_W:0] HALF    = {{ACC_W{1'b0}}, 1'b1} << (FRAC_BITS - 1);

    logic signed [ACC_W:0]              sum;
    logic signed [ACC_W:0]              shr;
    logic        [ACC_W-TOTAL_BITS+1:0] hi;

    // One extra bit keeps the rounding add from wrapping at the accumulator top.
    always_comb begin
        sum        = {acc_i[ACC_W-1], acc_i} + (round_en_i ? HALF : '0);
        shr        = sum >>> FRAC_BITS;
        hi         = shr[ACC_W:TOTAL_BITS-1];
        overflow_o = !((&hi) || !(|hi));
        if (overflow_o && sat_en_i)
            result_o = shr[ACC_W] ? SAT_MIN : SAT_MAX;
        else
            result_o = shr[TOTAL_BITS-1:0];
    end

endmodule

// File: rtl/fxp_mac_pipe.sv
// Three-stage signed fixed-point multiply-accumulate with a single global stall
// driven by the output handshake.
module fxp_mac_pipe
    import fxp_pkg::*;
#(
    parameter  int INT_BITS   = 8,
    parameter  int FRAC_BITS  = 8,
    parameter  int GUARD_BITS = 8,
    localparam int TOTAL_BITS = calc_total_bits(INT_BITS, FRAC_BITS),
    localparam int ACC_W      = calc_acc_w(TOTAL_BITS, GUARD_BITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [TOTAL_BITS-1:0] a_i,
    input  logic [TOTAL_BITS-1:0] b_i,
    input  logic                  acc_clr_i,
    input  logic                  acc_last_i,
    input  logic                  round_en_i,
    input  logic                  sat_en_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [TOTAL_BITS-1:0] result_o,
    output logic                  overflow_o
);

    localparam int PROD_W = 2 * TOTAL_BITS;

    logic        [1:0]            vld_pipe_q;
    beat_ctl_t                    s1_ctl_q, s2_ctl_q;
    logic signed [TOTAL_BITS-1:0] s1_a_q, s1_b_q;
    logic signed [PROD_W-1:0]     s2_prod_q, prod_d;
    logic signed [ACC_W-1:0]      acc_q, acc_d;
    logic        [TOTAL_BITS-1:0] result_q, conv_result;
    logic                         overflow_q, conv_overflow;
    logic                         out_valid_q;
    logic                         adv;

    // Every stage moves only when the output register is free to take a result.
    assign in_ready_o = !(out_valid_q && !out_ready_i);
    assign adv        = in_ready_o;

    assign prod_d = PROD_W'(s1_a_q) * PROD_W'(s1_b_q);
    assign acc_d  = s2_ctl_q.clr ? ACC_W'(s2_prod_q) : acc_q + ACC_W'(s2_prod_q);

    fxp_round_sat #(
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS),
        .TOTAL_BITS(TOTAL_BITS)
    ) u_round_sat (
        .acc_i     (acc_d),
        .round_en_i(s2_ctl_q.rnd),
        .sat_en_i  (s2_ctl_q.sat),
        .result_o  (conv_result),
        .overflow_o(conv_overflow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q  <= '0;
            s1_ctl_q    <= '0;
            s2_ctl_q    <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_prod_q   <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (adv) begin
            vld_pipe_q <= {vld_pipe_q[0], in_valid_i};
            s1_a_q     <= a_i;
            s1_b_q     <= b_i;
            s1_ctl_q   <= '{clr: acc_clr_i, last: acc_last_i, rnd: round_en_i, sat: sat_en_i};
            s2_prod_q  <= prod_d;
            s2_ctl_q   <= s1_ctl_q;
            if (vld_pipe_q[1])
                acc_q <= acc_d;
            // adv implies the previous result was taken, so valid simply reloads.
            out_valid_q <= vld_pipe_q[1] && s2_ctl_q.last;
            if (vld_pipe_q[1] && s2_ctl_q.last) begin
                result_q   <= conv_result;
                overflow_q <= conv_overflow;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_fxp_mac_pipe.sv
// Bench for fxp_mac_pipe at Q8.8: directed beats with literal expectations plus
// an arithmetic reference model checked on every valid output cycle.
module tb_fxp_mac_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, acc_clr, acc_last, round_en, sat_en;
    logic        out_valid, out_ready, overflow;
    logic [15:0] a, b, result;

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
    } exp_t;

    exp_t   expq[$];
    longint m_acc = 0;

    always #5 clk = ~clk;

    fxp_mac_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .a_i        (a),
        .b_i        (b),
        .acc_clr_i  (acc_clr),
        .acc_last_i (acc_last),
        .round_en_i (round_en),
        .sat_en_i   (sat_en),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o   (result),
        .overflow_o (overflow)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference conversion straight from the arithmetic rules (Q8.8 defaults).
    function automatic exp_t convert(longint acc, logic rnd, logic sat);
        longint v;
        exp_t   e;
        v = acc + (rnd ? 64'sd128 : 64'sd0);
        v = v >>> 8;
        if (v > 32767 || v < -32768) begin
            e.ovf = 1'b1;
            e.res = sat ? ((v > 0) ? 16'h7FFF : 16'h8000) : 16'(v);
        end else begin
            e.ovf = 1'b0;
            e.res = 16'(v);
        end
        return e;
    endfunction

    // Model: accumulate at acceptance, queue results, retire on handshake.
    always @(posedge clk or posedge rst) begin
        longint p;
        if (rst) begin
            expq.delete();
            m_acc = 0;
        end else begin
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (expq.size() > 0) void'(expq.pop_front());
            end
            if (in_valid && in_ready) begin
                p     = longint'($signed(a)) * longint'($signed(b));
                m_acc = acc_clr ? p : m_acc + p;
                m_acc = (m_acc <<< 24) >>> 24;
                if (acc_last) expq.push_back(convert(m_acc, round_en, sat_en));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready_rule", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
            if (out_valid) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: out_valid=1 result=%h, none expected", result);
                end else begin
                    chk("model_result", {16'd0, result}, {16'd0, expq[0].res});
                    chk("model_ovf", {31'd0, overflow}, {31'd0, expq[0].ovf});
                end
            end
        end
    end

    task automatic beat(logic [15:0] av, logic [15:0] bv, logic clr, logic last,
                        logic rnd, logic sat);
        int n = 0;
        in_valid = 1'b1; a = av; b = bv;
        acc_clr = clr; acc_last = last; round_en = rnd; sat_en = sat;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout: in_ready stuck at %b", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(string nm, logic [15:0] er, logic eo);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({nm, "_res"}, {16'd0, result}, {16'd0, er});
        chk({nm, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
        @(posedge clk);
        #1;
    endtask

    task automatic single(string nm, logic [15:0] av, logic [15:0] bv, logic rnd,
                          logic sat, logic [15:0] er, logic eo);
        int lat = 0;
        beat(av, bv, 1'b1, 1'b1, rnd, sat);
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        chk({nm, "_lat"}, lat, 32'd3);
        chk({nm, "_res"}, {16'd0, result}, {16'd0, er});
        chk({nm, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sa[6];
        int          h0;
        sa = '{16'h0100, 16'h0200, 16'h0300, 16'h7F00, 16'hFF00, 16'h0080};
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; acc_clr = 1'b0; acc_last = 1'b0;
        round_en = 1'b0; sat_en = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        single("mul_1p5x2", 16'h0180, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0);
        single("trunc_half", 16'h0001, 16'h0080, 1'b0, 1'b0, 16'h0000, 1'b0);
        single("round_half", 16'h0001, 16'h0080, 1'b1, 1'b0, 16'h0001, 1'b0);
        single("neg_trunc", 16'hFFFF, 16'h0080, 1'b0, 1'b0, 16'hFFFF, 1'b0);
        single("neg_round", 16'hFFFF, 16'h0080, 1'b1, 1'b0, 16'h0000, 1'b0);
        single("sat_pos", 16'h7F00, 16'h0200, 1'b0, 1'b1, 16'h7FFF, 1'b1);
        single("wrap_pos", 16'h7F00, 16'h0200, 1'b0, 1'b0, 16'hFE00, 1'b1);
        single("sat_neg", 16'h8000, 16'h0200, 1'b0, 1'b1, 16'h8000, 1'b1);

        // Four-beat accumulation, then a continuation without clear.
        h0 = hs_cnt;
        beat(16'h0100, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0);
        beat(16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(16'h0100, 16'h0100, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_out("acc4", 16'h0400, 1'b0);
        repeat (5) @(posedge clk);
        #1 chk("acc4_count", hs_cnt - h0, 32'd1);
        beat(16'h0100, 16'h0100, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_out("acc_cont", 16'h0500, 1'b0);

        // Back-to-back stream held off by out_ready for five cycles.
        h0 = hs_cnt;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) beat(sa[i], 16'h0200, 1'b1, 1'b1, 1'b0, 1'b1);
            end
            begin : stall_b
                int          n;
                logic [15:0] r0;
                n = 0;
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                r0 = result;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    chk("stall_valid", {31'd0, out_valid}, 32'd1);
                    chk("stall_result", {16'd0, result}, {16'd0, r0});
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        chk("stream_count", hs_cnt - h0, 32'd6);
        chk("stream_drained", expq.size(), 32'd0);

        // Reset while a result is stalled clears the output at once.
        out_ready = 1'b0;
        beat(16'h0100, 16'h0100, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_result", {16'd0, result}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0; out_ready = 1'b1;

        // Reset after two of four beats: nothing emerges, next accumulation is clean.
        h0 = hs_cnt;
        beat(16'h0100, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0);
        beat(16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1 chk("rst_mid_no_out", hs_cnt - h0, 32'd0);
        beat(16'h0200, 16'h0300, 1'b1, 1'b0, 1'b0, 1'b0);
        beat(16'h0100, 16'hFF00, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_out("fresh_acc", 16'h0500, 1'b0);
        repeat (4) @(posedge clk);
        #1 chk("fresh_count", hs_cnt - h0, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fxp_mac_pipe.md
FXP_MAC_PIPE -- requirements
Module: fxp_mac_pipe

Interface
REQ-001 Parameter INT_BITS, default 8, integer bits of operands and result.
REQ-002 Parameter FRAC_BITS, default 8, fractional bits of operands and result; TOTAL_BITS = INT_BITS+FRAC_BITS (derived, 16 at defaults).
REQ-003 Parameter GUARD_BITS, default 8, extra accumulator headroom bits; accumulator width ACC_W = 2*TOTAL_BITS+GUARD_BITS.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  input beat valid.
REQ-007 in_ready  out  1  block accepts a beat this cycle.
REQ-008 a, b  in  TOTAL_BITS each  signed two's-complement QINT.FRAC operands.
REQ-009 acc_clr  in  1  beat starts a new accumulation (loads, not adds).
REQ-010 acc_last  in  1  beat ends the accumulation; result emitted after it.
REQ-011 round_en  in  1  0 = truncate toward -inf, 1 = round half up; sampled with the beat.
REQ-012 sat_en  in  1  0 = wrap, 1 = saturate; sampled with the beat.
REQ-013 out_valid  out  1  result valid.
REQ-014 out_ready  in  1  downstream accepts result.
REQ-015 result  out  TOTAL_BITS  signed QINT.FRAC result.
REQ-016 overflow  out  1  result range exceeded before saturation/wrap; valid with out_valid.

Function
REQ-017 Beat accepted when in_valid && in_ready; in_ready = !(out_valid && !out_ready); all stages advance together on that same condition (global stall).
REQ-018 Stage 1 registers a, b, acc_clr, acc_last, round_en, sat_en and a valid bit; stage 2 registers the full 2*TOTAL_BITS signed product; stage 3 updates the accumulator and output register.
REQ-019 Latency: result for a beat with acc_last=1 appears with out_valid=1 exactly 3 cycles after acceptance absent stalls; beats with acc_last=0 produce no out_valid.
REQ-020 Accumulator: on valid stage-2 beat, acc = product if acc_clr else acc + sign-extended product, full ACC_W precision, wraps modulo 2^ACC_W if headroom exceeded.
REQ-021 acc_clr=1 and acc_last=1 on the same beat gives plain multiply behaviour (one beat in, one result out).
REQ-022 Output conversion of acc: add 2^(FRAC_BITS-1) if round_en, arithmetic shift right FRAC_BITS, then range check against [-2^(TOTAL_BITS-1), 2^(TOTAL_BITS-1)-1].
REQ-023 Out of range: overflow=1; result = nearest bound if sat_en, else low TOTAL_BITS bits; in range: overflow=0, result = value.
REQ-024 round_en/sat_en of the acc_last beat govern conversion.
REQ-025 While out_valid && !out_ready, result, overflow and out_valid hold stable and no beat is accepted.
REQ-026 out_valid clears on handshake unless a new acc_last beat completes in the same cycle, in which case it stays 1 with the new result.
REQ-027 Beat with acc_clr=0 after a completed accumulation adds to the previous accumulator value (no implicit clear).

Reset
REQ-028 rst asserted: all stage valid bits, accumulator, result, overflow, out_valid go to 0 immediately; in_ready = 1 after release.
REQ-029 rst mid-accumulation or mid-stall discards partial sums and in-flight beats; no result emitted for them.

Structure
REQ-030 Package fxp_pkg holds the ACC_W/TOTAL_BITS derivation functions and saturation-bound constants.
REQ-031 Combinational sub-module fxp_round_sat performs REQ-022/REQ-023 (parametrised by widths), instantiated once in stage 3.

Verification (defaults Q8.8)
REQ-032 a=0x0180, b=0x0200, clr=last=1 -> result 0x0300, overflow 0, 3 cycles latency.
REQ-033 a=0x0001, b=0x0080, clr=last=1 -> round_en=0: 0x0000; round_en=1: 0x0001.
REQ-034 a=0x7F00, b=0x0200 -> sat_en=1: 0x7FFF, overflow 1; sat_en=0: 0xFE00, overflow 1; a=0x8000, b=0x0200, sat_en=1 -> 0x8000, overflow 1.
REQ-035 4 beats a=b=0x0100, clr on 1st, last on 4th -> exactly one out_valid, result 0x0400.
REQ-036 Back-to-back single-beat stream with out_ready low 5 cycles -> in_ready low, result stable, no beat lost or duplicated after release.
REQ-037 rst pulsed after 2 of 4 accumulate beats -> no output; fresh accumulation afterwards correct.
